// File: rtl/bti_arb_n_if.sv
// Requester-side and bus-side BTI signal bundle for bti_arb_n.
// slave is the arbiter's view; master is the surrounding requesters and bus.
interface bti_arb_n_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]        in_req_vld;
  logic [NCH-1:0]        in_req_rdy;
  logic [NCH*AW-1:0]     in_req_addr;
  logic [NCH-1:0]        in_req_wen;
  logic [NCH*DW-1:0]     in_req_wdata;
  logic [NCH*DW/8-1:0]   in_req_wstrb;
  logic [NCH-1:0]        in_rsp_vld;
  logic [NCH-1:0]        in_rsp_rdy;
  logic [DW-1:0]         in_rsp_rdata;
  logic                  out_req_vld;
  logic                  out_req_rdy;
  logic [AW-1:0]         out_req_addr;
  logic                  out_req_wen;
  logic [DW-1:0]         out_req_wdata;
  logic [DW/8-1:0]       out_req_wstrb;
  logic                  out_rsp_vld;
  logic                  out_rsp_rdy;
  logic [DW-1:0]         out_rsp_rdata;
  logic                  rsp_orphan;

  modport slave (
    input  in_req_vld, in_req_addr, in_req_wen, in_req_wdata, in_req_wstrb, in_rsp_rdy,
           out_req_rdy, out_rsp_vld, out_rsp_rdata,
    output in_req_rdy, in_rsp_vld, in_rsp_rdata, out_req_vld, out_req_addr, out_req_wen,
           out_req_wdata, out_req_wstrb, out_rsp_rdy, rsp_orphan
  );

  modport master (
    output in_req_vld, in_req_addr, in_req_wen, in_req_wdata, in_req_wstrb, in_rsp_rdy,
           out_req_rdy, out_rsp_vld, out_rsp_rdata,
    input  in_req_rdy, in_rsp_vld, in_rsp_rdata, out_req_vld, out_req_addr, out_req_wen,
           out_req_wdata, out_req_wstrb, out_rsp_rdy, rsp_orphan
  );
endinterface

// File: rtl/bti_arb_n.sv
// N-channel BTI request arbiter with in-order response routing via a channel-index FIFO.
// Optional performance counters are enabled by defining BTI_ARB_PERF_EN.
module bti_arb_n #(
  parameter int NCH   = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int OST   = 4,
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  bti_arb_n_if.slave        bus
`ifdef BTI_ARB_PERF_EN
  ,
  output logic [NCH*32-1:0] perf_grant_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = (OST > 1) ? $clog2(OST) : 1;
  localparam int CW = $clog2(OST + 1);

  logic [IW-1:0]  rr_ptr_reg;
  logic [IW-1:0]  lock_ch_reg;
  logic           lock_vld_reg;
  logic [IW-1:0]  fifo_mem [OST];
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           orphan_reg;

  logic [IW-1:0]  grant;
  logic [IW-1:0]  rr_next;
  logic [IW-1:0]  head;
  logic [NCH-1:0] req_rdy;
  logic [NCH-1:0] rsp_vld;
  logic           any_vld, fifo_full, fifo_empty;
  logic           req_fire, rsp_fire, orphan_fire;

  assign any_vld    = |bus.in_req_vld;
  assign fifo_full  = (count_reg == CW'(OST));
  assign fifo_empty = (count_reg == '0);
  assign head       = fifo_mem[rd_ptr_reg];

  // With nothing valid the grant rests on the search start; the lock overrides everything.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    grant = RR_EN ? rr_ptr_reg : '0;
    for (int k = 0; k < NCH; k++) begin
      idx = RR_EN ? int'(rr_ptr_reg) + k : k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && bus.in_req_vld[idx]) begin
        grant = IW'(idx);
        found = 1'b1;
      end
    end
    if (lock_vld_reg) grant = lock_ch_reg;
  end

  assign rr_next = (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;

  assign bus.out_req_vld   = any_vld & ~fifo_full & ~rst;
  assign bus.out_req_addr  = bus.in_req_addr[int'(grant)*AW +: AW];
  assign bus.out_req_wen   = bus.in_req_wen[grant];
  assign bus.out_req_wdata = bus.in_req_wdata[int'(grant)*DW +: DW];
  assign bus.out_req_wstrb = bus.in_req_wstrb[int'(grant)*(DW/8) +: DW/8];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_route
      assign req_rdy[gi] = ~rst & bus.out_req_rdy & ~fifo_full & (grant == IW'(gi));
      assign rsp_vld[gi] = ~rst & bus.out_rsp_vld & ~fifo_empty & (head == IW'(gi));
    end
  endgenerate

  assign bus.in_req_rdy   = req_rdy;
  assign bus.in_rsp_vld   = rsp_vld;
  assign bus.in_rsp_rdata = bus.out_rsp_rdata;
  // An empty FIFO means no owner: accept and drop whatever the bus returns.
  assign bus.out_rsp_rdy  = ~rst & (fifo_empty ? bus.out_rsp_vld : bus.in_rsp_rdy[head]);
  assign bus.rsp_orphan   = orphan_reg;

  assign req_fire    = bus.out_req_vld & bus.out_req_rdy;
  assign rsp_fire    = bus.out_rsp_vld & bus.out_rsp_rdy & ~fifo_empty;
  assign orphan_fire = bus.out_rsp_vld & fifo_empty & ~rst;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == OST - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (req_fire) fifo_mem[wr_ptr_reg] <= grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg   <= '0;
      lock_ch_reg  <= '0;
      lock_vld_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      orphan_reg   <= 1'b0;
    end else begin
      if (req_fire) begin
        rr_ptr_reg   <= rr_next;
        lock_vld_reg <= 1'b0;
        wr_ptr_reg   <= ptr_inc(wr_ptr_reg);
      end else if (bus.out_req_vld) begin
        lock_vld_reg <= 1'b1;
        lock_ch_reg  <= grant;
      end
      if (rsp_fire) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({req_fire, rsp_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
      if (orphan_fire) orphan_reg <= 1'b1;
    end
  end

`ifdef BTI_ARB_PERF_EN
  logic [31:0] stall_cnt_reg;

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_perf
      logic [31:0] grant_cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) grant_cnt_reg <= '0;
        else if (req_fire && grant == IW'(gi)) grant_cnt_reg <= grant_cnt_reg + 1'b1;
      end
      assign perf_grant_cnt[gi*32 +: 32] = grant_cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_reg <= '0;
    else if (any_vld && fifo_full) stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign perf_stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_bti_arb_n.sv
// Bench for bti_arb_n: dut_a (NCH=3, round-robin, OST=3) and dut_b (NCH=3, fixed priority, OST=2).
// Vector table, hand sequences, and a randomized run against a queue-based reference model.
module tb_bti_arb_n;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  bti_arb_n_if #(.NCH(3), .AW(32), .DW(32)) bus_a ();
  bti_arb_n_if #(.NCH(3), .AW(32), .DW(32)) bus_b ();

`ifdef BTI_ARB_PERF_EN
  logic [95:0] perf_grant_a, perf_grant_b;
  logic [31:0] perf_stall_a, perf_stall_b;
`endif

  bti_arb_n #(.NCH(3), .AW(32), .DW(32), .OST(3), .RR_EN(1'b1)) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(bus_a)
`ifdef BTI_ARB_PERF_EN
    ,
    .perf_grant_cnt(perf_grant_a),
    .perf_stall_cnt(perf_stall_a)
`endif
  );

  bti_arb_n #(.NCH(3), .AW(32), .DW(32), .OST(2), .RR_EN(1'b0)) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b)
`ifdef BTI_ARB_PERF_EN
    ,
    .perf_grant_cnt(perf_grant_b),
    .perf_stall_cnt(perf_stall_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic [2:0] v, input logic ordy, input logic rv, input logic [2:0] rrdy);
    bus_b.in_req_vld  = v;
    bus_b.out_req_rdy = ordy;
    bus_b.out_rsp_vld = rv;
    bus_b.in_rsp_rdy  = rrdy;
  endtask

  typedef struct {
    logic [2:0] vld;
    logic       ordy;
    logic       rv;
    logic [2:0] rrdy;
    logic       e_ovld;
    logic [2:0] e_rdy;
    logic [2:0] e_rsp;
    logic       e_ors;
  } vec_t;

  vec_t tbl [12];

  // Reference model state for dut_a: owner queue of outstanding requests, rotation start, lock.
  int   m_rr;
  int   m_lock;
  int   m_q[$];
  bit   m_orphan;
  int   exp_gcnt [3];
  int   exp_stall;

  function automatic int pick(input logic [2:0] v);
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (m_rr + k) % 3;
      if (v[c]) return c;
    end
    return m_rr;
  endfunction

  logic [31:0] r_addr [3];
  logic [31:0] r_wd   [3];
  logic        r_wen  [3];
  logic [3:0]  r_ws   [3];
  logic [2:0]  pend;

  initial begin
    tbl[0]  = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0};
    tbl[1]  = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0};
    tbl[2]  = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0};
    tbl[3]  = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[4]  = '{3'b011, 1'b1, 1'b1, 3'b111, 1'b0, 3'b000, 3'b001, 1'b1};
    tbl[5]  = '{3'b011, 1'b1, 1'b1, 3'b111, 1'b1, 3'b010, 3'b010, 1'b1};
    tbl[6]  = '{3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 3'b001, 1'b0};
    tbl[7]  = '{3'b100, 1'b0, 1'b1, 3'b001, 1'b1, 3'b000, 3'b001, 1'b1};
    tbl[8]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 3'b100, 3'b000, 1'b0};
    tbl[9]  = '{3'b000, 1'b0, 1'b1, 3'b010, 1'b0, 3'b000, 3'b010, 1'b1};
    tbl[10] = '{3'b000, 1'b0, 1'b1, 3'b100, 1'b0, 3'b000, 3'b100, 1'b1};
    tbl[11] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.in_req_vld = '0;  bus_a.in_req_addr = {32'hA2, 32'hA1, 32'hA0};
    bus_a.in_req_wen = '0;  bus_a.in_req_wdata = '0;  bus_a.in_req_wstrb = '0;
    bus_a.in_rsp_rdy = '0;  bus_a.out_req_rdy = 1'b0;
    bus_a.out_rsp_vld = 1'b0; bus_a.out_rsp_rdata = '0;
    bus_b.in_req_vld = '0;  bus_b.in_req_addr = {32'hB2, 32'hB1, 32'hB0};
    bus_b.in_req_wen = '0;  bus_b.in_req_wdata = '0;  bus_b.in_req_wstrb = '0;
    bus_b.in_rsp_rdy = '0;  bus_b.out_req_rdy = 1'b0;
    bus_b.out_rsp_vld = 1'b0; bus_b.out_rsp_rdata = '0;
    repeat (2) tick();

    // Requests are held off while reset is asserted.
    bus_a.in_req_vld = 3'b111;
    bus_a.out_req_rdy = 1'b1;
    @(negedge clk);
    chk("rst.out_req_vld", 64'(bus_a.out_req_vld), 64'd0);
    chk("rst.in_req_rdy", 64'(bus_a.in_req_rdy), 64'd0);
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.in_req_vld = '0;
    bus_a.out_req_rdy = 1'b0;
    @(negedge clk);
    chk("post_rst.out_req_vld", 64'(bus_a.out_req_vld), 64'd0);
    chk("post_rst.in_rsp_vld", 64'(bus_a.in_rsp_vld), 64'd0);
    chk("post_rst.out_rsp_rdy", 64'(bus_a.out_rsp_rdy), 64'd0);
    chk("post_rst.rsp_orphan", 64'(bus_a.rsp_orphan), 64'd0);
    tick();

    // Vector table on dut_a.
    for (int i = 0; i < 12; i++) begin
      bus_a.in_req_vld    = tbl[i].vld;
      bus_a.out_req_rdy   = tbl[i].ordy;
      bus_a.out_rsp_vld   = tbl[i].rv;
      bus_a.in_rsp_rdy    = tbl[i].rrdy;
      bus_a.out_rsp_rdata = 32'hD000_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("tbl%0d.out_req_vld", i), 64'(bus_a.out_req_vld), 64'(tbl[i].e_ovld));
      chk($sformatf("tbl%0d.in_req_rdy", i), 64'(bus_a.in_req_rdy), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.in_rsp_vld", i), 64'(bus_a.in_rsp_vld), 64'(tbl[i].e_rsp));
      chk($sformatf("tbl%0d.out_rsp_rdy", i), 64'(bus_a.out_rsp_rdy), 64'(tbl[i].e_ors));
      chk($sformatf("tbl%0d.in_rsp_rdata", i), 64'(bus_a.in_rsp_rdata), 64'(32'hD000_0000 + 32'(i)));
      $display("tbl row %0d: vld=%b ordy=%b rsp_vld=%b rsp_rdy=%b", i, tbl[i].vld, tbl[i].ordy,
               tbl[i].rv, tbl[i].rrdy);
      tick();
    end

    // dut_b: fixed priority, lock held through a stall, full blocking, orphan, reset.
    drive_b(3'b110, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.stall1.out_req_vld", 64'(bus_b.out_req_vld), 64'd1);
    chk("b.stall1.addr", 64'(bus_b.out_req_addr), 64'hB1);
    chk("b.stall1.in_req_rdy", 64'(bus_b.in_req_rdy), 64'd0);
    tick();
    drive_b(3'b111, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.stall2.addr", 64'(bus_b.out_req_addr), 64'hB1);
    tick();
    drive_b(3'b111, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.stall3.addr", 64'(bus_b.out_req_addr), 64'hB1);
    tick();
    drive_b(3'b111, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.hs_ch1.in_req_rdy", 64'(bus_b.in_req_rdy), 64'b010);
    chk("b.hs_ch1.addr", 64'(bus_b.out_req_addr), 64'hB1);
    $display("b: ch1 request accepted after stall");
    tick();
    drive_b(3'b101, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.hs_ch0.in_req_rdy", 64'(bus_b.in_req_rdy), 64'b001);
    chk("b.hs_ch0.addr", 64'(bus_b.out_req_addr), 64'hB0);
    tick();
    drive_b(3'b100, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.full.out_req_vld", 64'(bus_b.out_req_vld), 64'd0);
    chk("b.full.in_req_rdy", 64'(bus_b.in_req_rdy), 64'd0);
    tick();
    drive_b(3'b100, 1'b1, 1'b1, 3'b111);
    @(negedge clk);
    chk("b.rsp1.in_rsp_vld", 64'(bus_b.in_rsp_vld), 64'b010);
    chk("b.rsp1.out_rsp_rdy", 64'(bus_b.out_rsp_rdy), 64'd1);
    chk("b.rsp1.out_req_vld", 64'(bus_b.out_req_vld), 64'd0);
    tick();
    drive_b(3'b100, 1'b1, 1'b1, 3'b111);
    @(negedge clk);
    chk("b.pushpop.in_rsp_vld", 64'(bus_b.in_rsp_vld), 64'b001);
    chk("b.pushpop.in_req_rdy", 64'(bus_b.in_req_rdy), 64'b100);
    chk("b.pushpop.addr", 64'(bus_b.out_req_addr), 64'hB2);
    tick();
    drive_b(3'b001, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.after_pushpop.in_req_rdy", 64'(bus_b.in_req_rdy), 64'b001);
    tick();
    drive_b(3'b010, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.refull.out_req_vld", 64'(bus_b.out_req_vld), 64'd0);
    tick();
    drive_b(3'b000, 1'b0, 1'b1, 3'b100);
    @(negedge clk);
    chk("b.rsp_ch2.in_rsp_vld", 64'(bus_b.in_rsp_vld), 64'b100);
    chk("b.rsp_ch2.out_rsp_rdy", 64'(bus_b.out_rsp_rdy), 64'd1);
    tick();
    drive_b(3'b000, 1'b0, 1'b1, 3'b011);
    @(negedge clk);
    chk("b.rsp_ch0.in_rsp_vld", 64'(bus_b.in_rsp_vld), 64'b001);
    chk("b.rsp_ch0.out_rsp_rdy", 64'(bus_b.out_rsp_rdy), 64'd1);
    tick();
    drive_b(3'b000, 1'b0, 1'b1, 3'b000);
    @(negedge clk);
    chk("b.orphan.in_rsp_vld", 64'(bus_b.in_rsp_vld), 64'd0);
    chk("b.orphan.out_rsp_rdy", 64'(bus_b.out_rsp_rdy), 64'd1);
    chk("b.orphan.flag_before", 64'(bus_b.rsp_orphan), 64'd0);
    tick();
    drive_b(3'b000, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.orphan.flag_set", 64'(bus_b.rsp_orphan), 64'd1);
    chk("b.orphan.rdy_idle", 64'(bus_b.out_rsp_rdy), 64'd0);
    tick();
    tick();
    @(negedge clk);
    chk("b.orphan.flag_sticky", 64'(bus_b.rsp_orphan), 64'd1);
    tick();
    rst_b = 1'b1;
    drive_b(3'b111, 1'b1, 1'b1, 3'b111);
    @(negedge clk);
    chk("b.midrst.out_req_vld", 64'(bus_b.out_req_vld), 64'd0);
    chk("b.midrst.in_req_rdy", 64'(bus_b.in_req_rdy), 64'd0);
    chk("b.midrst.in_rsp_vld", 64'(bus_b.in_rsp_vld), 64'd0);
    tick();
    rst_b = 1'b0;
    drive_b(3'b000, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    chk("b.midrst.orphan_clr", 64'(bus_b.rsp_orphan), 64'd0);
    tick();

    // Randomized run on dut_a against the reference model.
    rst_a = 1'b1;
    bus_a.in_req_vld = '0;
    bus_a.out_rsp_vld = 1'b0;
    tick();
    rst_a = 1'b0;
    m_rr = 0;
    m_lock = -1;
    m_q.delete();
    m_orphan = 1'b0;
    exp_stall = 0;
    pend = '0;
    for (int c = 0; c < 3; c++) exp_gcnt[c] = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      int          g;
      bit          full, ovld, ordy, rv, ors;
      logic [2:0]  e_rdy, e_rsp, rrdy;
      logic [31:0] rd;
      for (int c = 0; c < 3; c++) begin
        if (!pend[c] && $urandom_range(0, 2) == 0) begin
          pend[c]   = 1'b1;
          r_addr[c] = $urandom;
          r_wd[c]   = $urandom;
          r_wen[c]  = 1'($urandom_range(0, 1));
          r_ws[c]   = 4'($urandom_range(0, 15));
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      rv   = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      rrdy = 3'($urandom_range(0, 7));
      rd   = $urandom;
      bus_a.in_req_vld    = pend;
      bus_a.in_req_addr   = {r_addr[2], r_addr[1], r_addr[0]};
      bus_a.in_req_wdata  = {r_wd[2], r_wd[1], r_wd[0]};
      bus_a.in_req_wen    = {r_wen[2], r_wen[1], r_wen[0]};
      bus_a.in_req_wstrb  = {r_ws[2], r_ws[1], r_ws[0]};
      bus_a.out_req_rdy   = ordy;
      bus_a.out_rsp_vld   = rv;
      bus_a.in_rsp_rdy    = rrdy;
      bus_a.out_rsp_rdata = rd;
      @(negedge clk);

      full  = (m_q.size() == 3);
      g     = pick(pend);
      ovld  = (pend != 3'b000) && !full;
      e_rdy = '0;
      if (ordy && !full) e_rdy[g] = 1'b1;
      e_rsp = '0;
      if (m_q.size() == 0) ors = rv;
      else begin
        ors = rrdy[m_q[0]];
        if (rv) e_rsp[m_q[0]] = 1'b1;
      end
      chk($sformatf("rnd%0d.out_req_vld", cyc), 64'(bus_a.out_req_vld), 64'(ovld));
      chk($sformatf("rnd%0d.in_req_rdy", cyc), 64'(bus_a.in_req_rdy), 64'(e_rdy));
      if (ovld) begin
        chk($sformatf("rnd%0d.addr", cyc), 64'(bus_a.out_req_addr), 64'(r_addr[g]));
        chk($sformatf("rnd%0d.wdata", cyc), 64'(bus_a.out_req_wdata), 64'(r_wd[g]));
        chk($sformatf("rnd%0d.wen", cyc), 64'(bus_a.out_req_wen), 64'(r_wen[g]));
        chk($sformatf("rnd%0d.wstrb", cyc), 64'(bus_a.out_req_wstrb), 64'(r_ws[g]));
      end
      chk($sformatf("rnd%0d.in_rsp_vld", cyc), 64'(bus_a.in_rsp_vld), 64'(e_rsp));
      chk($sformatf("rnd%0d.out_rsp_rdy", cyc), 64'(bus_a.out_rsp_rdy), 64'(ors));
      chk($sformatf("rnd%0d.in_rsp_rdata", cyc), 64'(bus_a.in_rsp_rdata), 64'(rd));
      chk($sformatf("rnd%0d.rsp_orphan", cyc), 64'(bus_a.rsp_orphan), 64'(m_orphan));

      if (pend != 3'b000 && full) exp_stall++;
      if (rv && ors) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_orphan = 1'b1;
      end
      if (ovld && ordy) begin
        m_q.push_back(g);
        m_rr = (g + 1) % 3;
        m_lock = -1;
        pend[g] = 1'b0;
        exp_gcnt[g]++;
        $display("rnd%0d: grant ch%0d addr=%08h wen=%0d", cyc, g, r_addr[g], r_wen[g]);
      end else if (ovld) begin
        m_lock = g;
      end
      tick();
    end

`ifdef BTI_ARB_PERF_EN
    @(negedge clk);
    for (int c = 0; c < 3; c++)
      chk($sformatf("perf_grant_cnt[%0d]", c), 64'(perf_grant_a[c*32 +: 32]), 64'(exp_gcnt[c]));
    chk("perf_stall_cnt", 64'(perf_stall_a), 64'(exp_stall));
    tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    @(negedge clk);
    chk("perf_grant_cnt.rst", 64'(perf_grant_a[63:0]) | 64'(perf_grant_a[95:64]), 64'd0);
    chk("perf_stall_cnt.rst", 64'(perf_stall_a), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
